mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Multi-cycle sequencer for the RV32M multiply/divide unit; it is launched by the decoder's start strobe for funct7=0000001 R-type ops.
- Latches operands and funct3, then runs an iterative shift-add multiplier or a restoring divider, one bit per cycle.
- Drives busy to the hazard unit, which stalls the pipeline while busy is high.
- Returns a registered result with a one-cycle done pulse to the execute/writeback path.

Parameters:
XLEN, 32, operand/result width.
CNT_W, $clog2(XLEN), iteration counter width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  launch request (decoder start, E stage)
funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  in  XLEN  rs1 value (forwarded)
src_b  in  XLEN  rs2 value (forwarded)
flush  in  1  kill in-flight op (branch/jump redirect)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result valid that cycle
result  out  XLEN  registered result, held until next done

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers=0. Reset has priority over everything, including mid-operation.
- FSM states: IDLE, RUN, FIN. busy = (state != IDLE); it is a registered-state decode.
- done is registered and defaults to 0 on every edge unless set below.
- IDLE, start=1 at edge k:
  - Latch funct3 and signed flags: MULH/DIV/REM both signed; MULHSU src_a signed only.
  - Latch |a| and |b| magnitudes, and result sign (quotient sign = sa^sb; remainder sign = sa).
  - Set counter=0 and go to RUN.
- Shortcut cases go IDLE->FIN directly at edge k, with the final value preloaded:
  - Divide by zero (src_b=0): DIV/DIVU -> all ones; REM/REMU -> src_a.
  - Signed overflow (DIV/REM, src_a=0x80000000, src_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- RUN: one iteration per edge.
  - Multiply: if multiplier LSB is set, add multiplicand into the 64-bit accumulator high half; shift right.
  - Divide: shift remainder:quotient left; trial-subtract divisor; if non-negative, keep the difference and set the quotient LSB.
  - Counter increments each edge; at the edge where counter==XLEN-1, go to FIN. That gives XLEN edges in RUN.
- FIN: at the next edge, result <= sign-fixed value, done <= 1, state <= IDLE.
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word of the (two's-complement negated if sign) 64-bit product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Latency from the start edge k:
  - Normal op: done high in the cycle after edge k+XLEN+1 (33 cycles of busy, then the done cycle with busy=0).
  - Shortcut: 1 busy cycle, done after edge k+1.
- start while busy=1 is ignored; the decoder/hazard unit must not reissue.
- flush=1 at an edge in any state: state <= IDLE, done stays 0, result unchanged.
  - flush and start in the same IDLE cycle: flush wins; nothing is launched.
  - flush in FIN: done is suppressed.
- Width rules:
  - Accumulator is 2*XLEN wide; remainder register is XLEN+1 wide (borrow bit).
  - Negation is two's complement modulo 2^width.
  - MUL low word is independent of signedness.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU compute a single-cycle signed (XLEN+1)x(XLEN+1) product at edge k and go IDLE->FIN. Done arrives after edge k+1 with 1 busy cycle. Divides are unchanged.
- Undefined: multiplies use the iterative path, identical in latency to divides.

Decomposition:
- Package mdu_pkg holds:
  - state enum typedef (IDLE/RUN/FIN);
  - funct3 localparams F3_MUL..F3_REMU;
  - the overflow-dividend constant.
- One sub-module, mdu_div_step: combinational single restoring-division iteration {rem_in, q_in, divisor} -> {rem_out, q_out}, instantiated once inside RUN.

Test Plan:
- Reset mid-RUN: start DIVU 100/7, assert rst at cycle 10 -> busy=0, done=0, result=0 next cycle; no later done.
- DIV -7/2: done after 33 busy cycles, result=0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE. MUL -> 0x00000001.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with exactly 1 busy cycle. DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Flush at RUN cycle 5 of DIV 20/3 -> IDLE next cycle, no done, result holds its previous value. New start of DIV 20/3 afterwards -> 6. Start+flush in the same cycle -> no launch.
- Start pulses while busy are ignored (single done). With MDU_FAST_MUL_EN: MUL 3x4 -> done after 1 busy cycle, result 12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// FSM state type, funct3 op codes and the signed-overflow dividend.
package mdu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Most negative XLEN_DEF-bit value; divided by -1 it overflows.
  localparam logic [XLEN_DEF-1:0] OVF_DIVIDEND = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/mdu_sequencer_if.sv
// Decoder/hazard-unit side bundle of the multiply/divide sequencer.
// master = issuing pipeline, slave = sequencer.
interface mdu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift remainder:quotient left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] q_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] q_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_in[XLEN-1:0], q_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    // The top bit of diff is the borrow: set means shifted < divisor.
    if (!diff[XLEN]) begin
      rem_out = diff;
      q_out   = {q_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted;
      q_out   = {q_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic          clk,
  input  logic          rst,
  mdu_sequencer_if.slave bus
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        f3_reg, f3_next;
  logic              neg_reg, neg_next;     // product / quotient sign
  logic              rneg_reg, rneg_next;   // remainder sign
  logic [XLEN-1:0]   opnd_reg, opnd_next;   // multiplicand or divisor
  logic [2*XLEN-1:0] acc_reg, acc_next;     // hi: partial product, lo: multiplier/quotient
  logic [XLEN:0]     rem_reg, rem_next;
  logic [XLEN-1:0]   result_reg, result_next;
  logic              done_reg, done_next;

  logic              a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     step_rem;
  logic [XLEN-1:0]   step_q;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_value;

  always_comb begin
    a_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
               (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
    b_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) ||
               (bus.funct3 == F3_REM);
    sa       = a_signed && bus.src_a[XLEN-1];
    sb       = b_signed && bus.src_b[XLEN-1];
    abs_a    = sa ? -bus.src_a : bus.src_a;
    abs_b    = sb ? -bus.src_b : bus.src_b;
    is_div   = bus.funct3[2];
    div_zero = (bus.src_b == '0);
    div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
               (bus.src_a == OVF_DIVIDEND[XLEN-1:0]) && (bus.src_b == '1);
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_prod;
  // Low 2*XLEN bits of the (XLEN+1)x(XLEN+1) signed product are exact.
  assign fast_prod = $signed({sa, bus.src_a}) * $signed({sb, bus.src_b});
`endif

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem_reg),
    .q_in    (acc_reg[XLEN-1:0]),
    .divisor (opnd_reg),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    prod_fix = neg_reg  ? -acc_reg : acc_reg;
    quo_fix  = neg_reg  ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fix  = rneg_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
    case (f3_reg)
      F3_MUL:                       fin_value = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fin_value = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fin_value = quo_fix;
      default:                      fin_value = rem_fix;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    f3_next     = f3_reg;
    neg_next    = neg_reg;
    rneg_next   = rneg_reg;
    opnd_next   = opnd_reg;
    acc_next    = acc_reg;
    rem_next    = rem_reg;
    result_next = result_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          f3_next  = bus.funct3;
          cnt_next = '0;
          rem_next = '0;
          if (is_div) begin
            opnd_next  = abs_b;
            acc_next   = {{XLEN{1'b0}}, abs_a};
            neg_next   = sa ^ sb;
            rneg_next  = sa;
            state_next = RUN;
            // Shortcuts preload quotient/remainder so FIN needs no special case.
            if (div_zero) begin
              acc_next   = {{XLEN{1'b0}}, {XLEN{1'b1}}};
              rem_next   = {1'b0, bus.src_a};
              neg_next   = 1'b0;
              rneg_next  = 1'b0;
              state_next = FIN;
            end else if (div_ovf) begin
              acc_next   = {{XLEN{1'b0}}, OVF_DIVIDEND[XLEN-1:0]};
              neg_next   = 1'b0;
              rneg_next  = 1'b0;
              state_next = FIN;
            end
          end else begin
`ifdef MDU_FAST_MUL_EN
            acc_next   = fast_prod;
            neg_next   = 1'b0;
            rneg_next  = 1'b0;
            state_next = FIN;
`else
            opnd_next  = abs_a;
            acc_next   = {{XLEN{1'b0}}, abs_b};
            neg_next   = sa ^ sb;
            rneg_next  = 1'b0;
            state_next = RUN;
`endif
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          if (f3_reg[2]) begin
            rem_next = step_rem;
            acc_next = {acc_reg[2*XLEN-1:XLEN], step_q};
          end else begin
            acc_next = {mul_sum, acc_reg[XLEN-1:1]};
          end
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(XLEN-1)) begin
            state_next = FIN;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
        if (!bus.flush) begin
          done_next   = 1'b1;
          result_next = fin_value;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      f3_reg     <= '0;
      neg_reg    <= 1'b0;
      rneg_reg   <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      f3_reg     <= f3_next;
      neg_reg    <= neg_next;
      rneg_reg   <= rneg_next;
      opnd_reg   <= opnd_next;
      acc_reg    <= acc_next;
      rem_reg    <= rem_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed ops push expected result and
// busy-cycle count; a negedge monitor pops and compares on every done pulse.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.XLEN(32)) bus();

  mdu_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: measures busy run length and scores every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else if (bus.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with result %h, expected no done", bus.result);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
        $display("txn %s: result %h busy_cycles %0d", e.name, bus.result, busy_cnt);
      end
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic flush_too);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.flush  = flush_too;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic expect_done(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    e.name = name;
    e.res  = exp;
    e.lat  = lat;
    sb_q.push_back(e);
    issue(f3, a, b, 1'b0);
    repeat (lat + 2) @(negedge clk);
    expect_done(name);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish within 500000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.flush  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, bus.busy}, 32'd0);
    check("reset_done",   {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result,        32'd0);
    rst = 1'b0;

    run_op("div_m7_2",    F3_DIV,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2",    F3_REM,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, DIV_LAT);
    run_op("mulh_min",    F3_MULH,   32'h8000_0000, 32'h8000_0000,  32'h4000_0000, MUL_LAT);
    run_op("mulhsu_ones", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu_ones",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, MUL_LAT);
    run_op("mul_ones",    F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0001, MUL_LAT);

    // Reset mid-RUN clears everything and the aborted op never completes.
    issue(F3_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_busy",   {31'b0, bus.busy}, 32'd0);
    check("midrun_reset_done",   {31'b0, bus.done}, 32'd0);
    check("midrun_reset_result", bus.result,        32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    run_op("divu_100_7",  F3_DIVU, 32'd100,        32'd7,          32'd14,        DIV_LAT);
    run_op("remu_100_7",  F3_REMU, 32'd100,        32'd7,          32'd2,         DIV_LAT);
    run_op("divu_5_0",    F3_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
    run_op("remu_5_0",    F3_REMU, 32'd5,          32'd0,          32'd5,         1);
    run_op("div_ovf",     F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);
    run_op("rem_ovf",     F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1);
    run_op("div_7_0",     F3_DIV,  32'd7,          32'd0,          32'hFFFF_FFFF, 1);
    run_op("rem_m7_0",    F3_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 1);
    run_op("div_m20_3",   F3_DIV,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA, DIV_LAT);
    run_op("rem_20_m3",   F3_REM,  32'd20,         32'hFFFF_FFFD,  32'd2,         DIV_LAT);

    // Flush during RUN: back to IDLE, no done, result keeps the last value (2).
    issue(F3_DIV, 32'd20, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy",   {31'b0, bus.busy}, 32'd0);
    check("flush_result", bus.result,        32'd2);
    repeat (40) @(negedge clk);

    run_op("div_20_3", F3_DIV, 32'd20, 32'd3, 32'd6, DIV_LAT);

    // start and flush together: nothing launches.
    issue(F3_DIVU, 32'd9, 32'd3, 1'b1);
    check("start_flush_busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("start_flush_result", bus.result, 32'd6);

    // A second start while busy is ignored: exactly one done with the first result.
    e.name = "divu_busy_restart";
    e.res  = 32'd14;
    e.lat  = DIV_LAT;
    sb_q.push_back(e);
    issue(F3_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    issue(F3_REMU, 32'd55, 32'd10, 1'b0);
    repeat (DIV_LAT) @(negedge clk);
    expect_done("divu_busy_restart");
    repeat (40) @(negedge clk);

    run_op("mul_3_4",     F3_MUL,   32'd3,         32'd4,  32'd12, MUL_LAT);
    run_op("mulhu_small", F3_MULHU, 32'h1234_5678, 32'h10, 32'd1,  MUL_LAT);

    repeat (5) @(negedge clk);
    expect_done("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
